rca_pr_scheduler: RTL and testbench

//  Sequences partial reconfiguration (PR) of the RCA slots. Takes slot/config requests from the hardware profiler
//  and from software (PR queue), round-robin arbitrates them into a request FIFO, locks the target slot, waits for
//  in-flight RCA ops on it to drain, starts the PR engine and records the loaded config per slot. Sits between
//  rca_profiler/axi_pr_queue and the RCA grid; drives pr_request_pending.

---
 rtl/rca_pr_scheduler.sv | 169 ++++++++++++++++
 tb/tb_rca_pr_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pr_scheduler.sv
// Partial-reconfiguration scheduler for the RCA slots: arbitrates profiler/software
// requests into a small FIFO, then locks, drains, reconfigures and records each slot.
module rca_pr_scheduler #(
    parameter int NUM_SLOTS  = 3,
    parameter int CFG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024,
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prof_req_valid,
    output logic                       prof_req_ready,
    input  logic [SLOT_W-1:0]          prof_req_slot,
    input  logic [CFG_W-1:0]           prof_req_cfg,
    input  logic                       sw_req_valid,
    output logic                       sw_req_ready,
    input  logic [SLOT_W-1:0]          sw_req_slot,
    input  logic [CFG_W-1:0]           sw_req_cfg,
    input  logic [NUM_SLOTS-1:0]       slot_busy,
    input  logic                       pr_done,
    input  logic                       err_clr,
    output logic [NUM_SLOTS-1:0]       slot_lock,
    output logic                       pr_start,
    output logic [SLOT_W-1:0]          pr_slot,
    output logic [CFG_W-1:0]           pr_cfg,
    output logic [NUM_SLOTS-1:0]       loaded_valid,
    output logic [NUM_SLOTS*CFG_W-1:0] loaded_cfg,
    output logic                       pr_error,
    output logic                       pr_request_pending
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t state, state_n;

    logic [SLOT_W-1:0] fifo_slot [FIFO_DEPTH];
    logic [CFG_W-1:0]  fifo_cfg  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full, fifo_empty;

    logic              prio_sw;
    logic              grant_prof, grant_sw, push, pop;
    logic [SLOT_W-1:0] push_slot, head_slot, cur_slot;
    logic [CFG_W-1:0]  push_cfg, head_cfg, cur_cfg;
    logic              head_dup;
    logic [CFG_W-1:0]  loaded_tab [NUM_SLOTS];
    logic [TMO_W-1:0]  tmo_cnt;
    logic              done_hit, tmo_hit;

    // Fullness uses the registered count, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count == '0);
        grant_prof = 1'b0;
        grant_sw   = 1'b0;
        if (rst && !fifo_full) begin
            if (prof_req_valid && sw_req_valid) begin
                grant_sw   = prio_sw;
                grant_prof = !prio_sw;
            end else begin
                grant_prof = prof_req_valid;
                grant_sw   = sw_req_valid;
            end
        end
        push_slot      = grant_sw ? sw_req_slot : prof_req_slot;
        push_cfg       = grant_sw ? sw_req_cfg  : prof_req_cfg;
        push           = (grant_sw || grant_prof) && ({1'b0, push_slot} < SLOT_LIMIT);
        prof_req_ready = grant_prof;
        sw_req_ready   = grant_sw;
    end

    always_comb begin
        head_slot = fifo_slot[rd_ptr];
        head_cfg  = fifo_cfg[rd_ptr];
        head_dup  = loaded_valid[head_slot] && (loaded_tab[head_slot] == head_cfg);
        pop       = (state == S_IDLE) && !fifo_empty;
    end

    always_comb begin
        state_n   = state;
        done_hit  = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE:    if (pop && !head_dup) state_n = S_LOCK;
            S_LOCK:    if (!slot_busy[cur_slot]) state_n = S_START;
            S_START:   state_n = S_WAIT;
            S_WAIT: begin
                if (pr_done) begin
                    done_hit = 1'b1;
                    state_n  = S_RELEASE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_n = S_RELEASE;
                end
            end
            S_RELEASE: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        slot_lock = '0;
        if (state != S_IDLE) slot_lock[cur_slot] = 1'b1;
        pr_start           = (state == S_START);
        pr_slot            = cur_slot;
        pr_cfg             = cur_cfg;
        pr_request_pending = !fifo_empty || (state != S_IDLE);
        loaded_cfg         = '0;
        for (int i = 0; i < NUM_SLOTS; i++) loaded_cfg[i*CFG_W +: CFG_W] = loaded_tab[i];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_slot[wr_ptr] <= push_slot;
            fifo_cfg[wr_ptr]  <= push_cfg;
        end
    end

    // A timeout in the same cycle as err_clr keeps the error flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            prio_sw      <= 1'b1;
            cur_slot     <= '0;
            cur_cfg      <= '0;
            tmo_cnt      <= '0;
            pr_error     <= 1'b0;
            loaded_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) loaded_tab[i] <= '0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_slot <= head_slot;
                cur_cfg  <= head_cfg;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (grant_sw) prio_sw <= 1'b0;
            else if (grant_prof) prio_sw <= 1'b1;
            if (state == S_START) tmo_cnt <= '0;
            else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            if (done_hit) begin
                loaded_tab[cur_slot]   <= cur_cfg;
                loaded_valid[cur_slot] <= 1'b1;
            end
            if (tmo_hit) loaded_valid[cur_slot] <= 1'b0;
            if (tmo_hit) pr_error <= 1'b1;
            else if (err_clr) pr_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rca_pr_scheduler.sv
// Bench for rca_pr_scheduler: a queue-based request/job model checked every cycle,
// plus directed scenarios with hand-computed expectations at key cycles.
module tb_rca_pr_scheduler;

    localparam int NUM_SLOTS  = 3;
    localparam int CFG_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 1024;
    localparam int SLOT_W     = 2;

    localparam int P_NONE = 0, P_DRAIN = 1, P_KICK = 2, P_LOADING = 3, P_UNLOCK = 4;

    logic clk, rst;
    logic prof_req_valid, prof_req_ready, sw_req_valid, sw_req_ready;
    logic [SLOT_W-1:0] prof_req_slot, sw_req_slot, pr_slot;
    logic [CFG_W-1:0] prof_req_cfg, sw_req_cfg, pr_cfg;
    logic [NUM_SLOTS-1:0] slot_busy, slot_lock, loaded_valid;
    logic [NUM_SLOTS*CFG_W-1:0] loaded_cfg;
    logic pr_done, err_clr, pr_start, pr_error, pr_request_pending;

    rca_pr_scheduler #(
        .NUM_SLOTS(NUM_SLOTS), .CFG_W(CFG_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .prof_req_valid(prof_req_valid), .prof_req_ready(prof_req_ready),
        .prof_req_slot(prof_req_slot), .prof_req_cfg(prof_req_cfg),
        .sw_req_valid(sw_req_valid), .sw_req_ready(sw_req_ready),
        .sw_req_slot(sw_req_slot), .sw_req_cfg(sw_req_cfg),
        .slot_busy(slot_busy), .pr_done(pr_done), .err_clr(err_clr),
        .slot_lock(slot_lock), .pr_start(pr_start), .pr_slot(pr_slot), .pr_cfg(pr_cfg),
        .loaded_valid(loaded_valid), .loaded_cfg(loaded_cfg),
        .pr_error(pr_error), .pr_request_pending(pr_request_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [CFG_W-1:0]  cfg;
    } req_t;

    req_t m_q[$];
    bit m_prio_sw;
    int m_phase, m_wait;
    logic [SLOT_W-1:0] m_slot;
    logic [CFG_W-1:0] m_cfg;
    bit m_valid[NUM_SLOTS];
    logic [CFG_W-1:0] m_tab[NUM_SLOTS];
    bit m_err;

    int n_pass = 0, n_checks = 0;
    bit check_en = 0, auto_done = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    function automatic void modelGrant(output bit gp, output bit gs);
        gp = 0;
        gs = 0;
        if (rst === 1'b1 && m_q.size() < FIFO_DEPTH) begin
            if (prof_req_valid && sw_req_valid) begin
                gs = m_prio_sw;
                gp = !m_prio_sw;
            end else begin
                gp = prof_req_valid;
                gs = sw_req_valid;
            end
        end
    endfunction

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic modelStep();
        bit gp, gs, tmo;
        req_t r;
        modelGrant(gp, gs);
        tmo = 0;
        if (rst !== 1'b1) begin
            m_q.delete();
            m_prio_sw = 1;
            m_phase = P_NONE;
            m_wait = 0;
            m_slot = '0;
            m_cfg = '0;
            m_err = 0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                m_valid[i] = 0;
                m_tab[i] = '0;
            end
        end else begin
            case (m_phase)
                P_NONE: if (m_q.size() > 0) begin
                    r = m_q.pop_front();
                    m_slot = r.slot;
                    m_cfg = r.cfg;
                    if (!(m_valid[r.slot] && m_tab[r.slot] == r.cfg)) m_phase = P_DRAIN;
                end
                P_DRAIN: if (!slot_busy[m_slot]) m_phase = P_KICK;
                P_KICK: begin
                    m_phase = P_LOADING;
                    m_wait = 0;
                end
                P_LOADING: begin
                    m_wait++;
                    if (pr_done) begin
                        m_tab[m_slot] = m_cfg;
                        m_valid[m_slot] = 1;
                        m_phase = P_UNLOCK;
                    end else if (m_wait == TIMEOUT) begin
                        tmo = 1;
                        m_valid[m_slot] = 0;
                        m_phase = P_UNLOCK;
                    end
                end
                default: m_phase = P_NONE;
            endcase
            if (tmo) m_err = 1;
            else if (err_clr) m_err = 0;
            if (gp || gs) begin
                r.slot = gs ? sw_req_slot : prof_req_slot;
                r.cfg  = gs ? sw_req_cfg : prof_req_cfg;
                if (r.slot < NUM_SLOTS) m_q.push_back(r);
                m_prio_sw = gp;
            end
        end
    endtask

    task automatic checkOutput();
        bit gp, gs;
        logic [NUM_SLOTS-1:0] e_lock, e_valid;
        logic [NUM_SLOTS*CFG_W-1:0] e_cfg;
        if (check_en) begin
            modelGrant(gp, gs);
            e_lock = '0;
            if (m_phase != P_NONE) e_lock[m_slot] = 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                e_valid[i] = m_valid[i];
                e_cfg[i*CFG_W +: CFG_W] = m_tab[i];
            end
            cmp("prof_req_ready", prof_req_ready, gp);
            cmp("sw_req_ready", sw_req_ready, gs);
            cmp("slot_lock", slot_lock, e_lock);
            cmp("pr_start", pr_start, m_phase == P_KICK);
            if (m_phase != P_NONE) begin
                cmp("pr_slot", pr_slot, m_slot);
                cmp("pr_cfg", pr_cfg, m_cfg);
            end
            cmp("loaded_valid", loaded_valid, e_valid);
            cmp("loaded_cfg", loaded_cfg, e_cfg);
            cmp("pr_error", pr_error, m_err);
            cmp("pr_request_pending", pr_request_pending, (m_q.size() > 0) || (m_phase != P_NONE));
        end
    endtask

    task automatic applyStimulus(input bit pv, input int ps, input int pc,
                                 input bit sv, input int ss, input int sc);
        prof_req_valid = pv;
        prof_req_slot  = SLOT_W'(ps);
        prof_req_cfg   = CFG_W'(pc);
        sw_req_valid   = sv;
        sw_req_slot    = SLOT_W'(ss);
        sw_req_cfg     = CFG_W'(sc);
    endtask

    task automatic cycle();
        if (auto_done) pr_done = (m_phase == P_LOADING);
        #1;
        checkOutput();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        slot_busy = '0;
        pr_done = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b1;
        check_en = 1;
        #1;
        cmp("reset_pending", pr_request_pending, 0);
        cmp("reset_lock", slot_lock, 0);
        cmp("reset_loaded_valid", loaded_valid, 0);
        cmp("reset_pr_slot", pr_slot, 0);

        // Single software request to an idle slot.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 0, 0, c == 0, 1, 5);
            pr_done = (c == 4);
            #1;
            if (c == 0) cmp("first_sw_ready", sw_req_ready, 1);
            if (c == 1 || c == 2) cmp("first_no_early_start", pr_start, 0);
            if (c == 3) begin
                cmp("first_start_cycle3", pr_start, 1);
                cmp("first_pr_slot", pr_slot, 1);
                cmp("first_pr_cfg", pr_cfg, 5);
            end
            if (c == 5) begin
                cmp("first_lock_in_release", slot_lock, 3'b010);
                cmp("first_loaded_cfg1", loaded_cfg[7:4], 5);
                cmp("first_loaded_valid1", loaded_valid[1], 1);
            end
            if (c == 6) cmp("first_lock_cleared", slot_lock, 0);
            cycle();
        end

        // Duplicate of the loaded config, then a request to a nonexistent slot.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 0, c == 0, 1, 5);
            #1;
            if (c == 1) cmp("dup_pending_while_queued", pr_request_pending, 1);
            if (c == 2) begin
                cmp("dup_pending_dropped", pr_request_pending, 0);
                cmp("dup_no_lock", slot_lock, 0);
                cmp("dup_no_start", pr_start, 0);
            end
            cycle();
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, c == 0, 3, 7);
            #1;
            if (c == 0) cmp("badslot_accepted", sw_req_ready, 1);
            if (c == 1) cmp("badslot_not_queued", pr_request_pending, 0);
            cycle();
        end

        // Both requesters valid every cycle; FIFO fills and then drains.
        auto_done = 1;
        for (int c = 0; c < 60; c++) begin
            applyStimulus(c < 8, (c % 2) ? 2 : 0, c + 1, c < 8, (c % 2) ? 2 : 0, c + 8);
            #1;
            if (c == 0) begin
                cmp("rr_c0_prof", prof_req_ready, 1);
                cmp("rr_c0_sw", sw_req_ready, 0);
            end
            if (c == 1) begin
                cmp("rr_c1_prof", prof_req_ready, 0);
                cmp("rr_c1_sw", sw_req_ready, 1);
            end
            if (c == 5 || c == 6) cmp("rr_full_blocks", {prof_req_ready, sw_req_ready}, 0);
            if (c == 7) cmp("rr_after_full_sw", sw_req_ready, 1);
            cycle();
        end

        // Busy slot holds the reconfiguration in the lock phase.
        for (int c = 0; c < 16; c++) begin
            applyStimulus(0, 0, 0, c == 0, 2, 9);
            slot_busy = (c < 10) ? 3'b100 : 3'b000;
            #1;
            if (c == 5) begin
                cmp("busy_lock_held", slot_lock, 3'b100);
                cmp("busy_no_start", pr_start, 0);
            end
            if (c == 10) cmp("busy_fall_no_start", pr_start, 0);
            if (c == 11) cmp("busy_start_after_fall", pr_start, 1);
            cycle();
        end
        slot_busy = '0;

        // Two timeouts back to back; err_clr on the second timeout cycle loses.
        auto_done = 0;
        pr_done = 1'b0;
        for (int c = 0; c < 2061; c++) begin
            applyStimulus(c == 5, 1, 6, c == 0, 0, 3);
            err_clr = (c == 2055) || (c == 2058);
            #1;
            if (c == 1027) cmp("tmo_no_error_yet", pr_error, 0);
            if (c == 1028) begin
                cmp("tmo_error_set", pr_error, 1);
                cmp("tmo_slot0_invalid", loaded_valid[0], 0);
                cmp("tmo_lock_release", slot_lock, 3'b001);
            end
            if (c == 1031) begin
                cmp("tmo_next_start", pr_start, 1);
                cmp("tmo_next_slot", pr_slot, 1);
            end
            if (c == 2056) begin
                cmp("tmo_wins_over_clr", pr_error, 1);
                cmp("tmo_slot1_invalid", loaded_valid[1], 0);
            end
            if (c == 2059) cmp("err_clr_clears", pr_error, 0);
            cycle();
        end
        err_clr = 1'b0;

        // pr_done on the last allowed wait cycle beats the timeout.
        for (int c = 0; c < 1031; c++) begin
            applyStimulus(0, 0, 0, c == 0, 2, 4);
            pr_done = (c == 1027);
            #1;
            if (c == 3) cmp("late_done_start", pr_start, 1);
            if (c == 1028) begin
                cmp("late_done_no_error", pr_error, 0);
                cmp("late_done_cfg2", loaded_cfg[11:8], 4);
                cmp("late_done_valid2", loaded_valid[2], 1);
            end
            cycle();
        end

        // Reset while waiting for pr_done, with a request still queued.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c == 4, 1, 2, c == 0, 0, 11);
            rst = (c == 5) ? 1'b0 : 1'b1;
            pr_done = (c == 6 || c == 7);
            #1;
            if (c == 5) cmp("midrst_lock_before", slot_lock, 3'b001);
            if (c == 6) begin
                cmp("midrst_lock", slot_lock, 0);
                cmp("midrst_pending", pr_request_pending, 0);
                cmp("midrst_valid", loaded_valid, 0);
                cmp("midrst_cfg", loaded_cfg, 0);
                cmp("midrst_outs", {pr_start, pr_error, pr_slot, pr_cfg}, 0);
            end
            if (c == 8) begin
                cmp("midrst_late_done_ignored", loaded_valid, 0);
                cmp("midrst_still_idle", pr_request_pending, 0);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
